// File: rtl/sram_like_data_mem.sv
// Single-port data memory slave on the SRAM-like req/addr_ok/data_ok bus.
// One transaction at a time, with programmable accept and data-return latencies.
//
// state | meaning
// IDLE  | counting req cycles toward ADDR_LAT, accepting when reached
// WAIT  | transaction latched, dcnt counting down DATA_LAT
// RESP  | data_ok cycle; read returns word, write commits at clock edge
module sram_like_data_mem #(
  parameter int unsigned ADDR_LAT = 1,
  parameter int unsigned DATA_LAT = 2,
  parameter int unsigned MEM_AW   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] ALAT = 4'(ADDR_LAT);
  localparam logic [3:0] DLAT = 4'(DATA_LAT);

  state_t            state, state_nxt;
  logic [3:0]        acnt, dcnt;
  logic              accept;
  logic              wr_q;
  logic [MEM_AW-1:0] idx_q;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, rdata_q, bmask;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic              unused_addr;

  assign unused_addr = ^{data_addr[31:MEM_AW+2]};
  assign accept      = data_req && (state == IDLE) && (acnt == ALAT);
  assign bmask       = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};

  always_comb begin
    mask_d = 4'b1111;
    case (data_size)
      2'b00:   mask_d = 4'b0001 << data_addr[1:0];
      2'b01:   mask_d = data_addr[1] ? 4'b1100 : 4'b0011;
      default: mask_d = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (DLAT == 4'd0) ? RESP : WAIT;
      WAIT:    if (dcnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is visible combinationally in RESP; the register holds it afterwards.
  always_comb begin
    data_addr_ok = accept;
    data_data_ok = (state == RESP);
    data_rdata   = rdata_q;
    if (state == RESP && !wr_q) data_rdata = mem[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acnt     <= '0;
      dcnt     <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state != IDLE || accept || !data_req) acnt <= '0;
      else if (acnt < ALAT)                     acnt <= acnt + 4'd1;

      if (accept) begin
        wr_q    <= data_wr;
        idx_q   <= data_addr[MEM_AW+1:2];
        mask_q  <= mask_d;
        wdata_q <= data_wdata;
        dcnt    <= DLAT;
      end else if (state == WAIT) begin
        dcnt <= dcnt - 4'd1;
      end

      if (state == RESP) begin
        if (wr_q) begin
          wr_count <= wr_count + 32'd1;
        end else begin
          rd_count <= rd_count + 32'd1;
          rdata_q  <= mem[idx_q];
        end
      end
    end
  end

  // Contents are deliberately not reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && wr_q)
      mem[idx_q] <= (mem[idx_q] & ~bmask) | (wdata_q & bmask);
  end

endmodule

// File: tb/tb_sram_like_data_mem.sv
// Directed bench for sram_like_data_mem: three instances with different
// latency/depth settings share the bus fields but have separate req lines.
module tb_sram_like_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'b10;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [2:0]  aok, dok;
  logic [31:0] rdata [3];
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
  int          exp_rd [3];
  int          exp_wr [3];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sram_like_data_mem #(.ADDR_LAT(1), .DATA_LAT(2), .MEM_AW(10)) u_a (
    .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(rdata[0]),
    .data_addr_ok(aok[0]), .data_data_ok(dok[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

  sram_like_data_mem #(.ADDR_LAT(0), .DATA_LAT(0), .MEM_AW(12)) u_z (
    .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(rdata[1]),
    .data_addr_ok(aok[1]), .data_data_ok(dok[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

  sram_like_data_mem #(.ADDR_LAT(3), .DATA_LAT(1), .MEM_AW(12)) u_w (
    .clk(clk), .rst(rst), .data_req(req[2]), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(rdata[2]),
    .data_addr_ok(aok[2]), .data_data_ok(dok[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on unit u; called and returns at posedge+1.
  task automatic txn(input int u, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic scr, input int exp_la, input int exp_ld,
                     input logic chk_rd, input logic [31:0] exp_rdata);
    int la, ld;
    bit ok;
    logic [31:0] rd;
    rd = '0;
    data_wr = w; data_size = sz; data_addr = a; data_wdata = d; req[u] = 1'b1;
    la = 0; ok = 0;
    while (!ok && la < 40) begin
      @(negedge clk);
      if (aok[u]) ok = 1;
      else begin @(posedge clk); #1; la++; end
    end
    chk("accept_lat", 32'(la), 32'(exp_la));
    @(posedge clk); #1;
    req[u] = 1'b0;
    if (scr) begin data_addr = ~a; data_wdata = ~d; data_size = ~sz; data_wr = ~w; end
    ld = 1; ok = 0;
    while (!ok && ld < 40) begin
      @(negedge clk);
      if (dok[u]) begin ok = 1; rd = rdata[u]; chk("aok_in_resp", {31'd0, aok[u]}, 32'd0); end
      else begin @(posedge clk); #1; ld++; end
    end
    chk("data_lat", 32'(ld), 32'(exp_ld));
    @(posedge clk); #1;
    if (w) exp_wr[u]++; else exp_rd[u]++;
    chk("rd_count", rdc[u], 32'(exp_rd[u]));
    chk("wr_count", wrc[u], 32'(exp_wr[u]));
    if (chk_rd) chk("rdata", rd, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  ap, dp;
    logic [31:0] r1, r3, r5;
    bit          seen;
    int          k;
    for (int i = 0; i < 3; i++) begin exp_rd[i] = 0; exp_wr[i] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_aok", {29'd0, aok}, 32'h0);
    chk("rst_dok", {29'd0, dok}, 32'h0);
    chk("rst_rdc", rdc[0], 32'h0);
    chk("rst_wrc", wrc[0], 32'h0);
    @(posedge clk); #1;

    // read with latencies 1/2
    txn(0, 1'b1, 2'b10, 32'h14, 32'h11223344, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h14, 32'h0,        1'b0, 1, 3, 1'b1, 32'h11223344);

    // byte / half / size-11 masking
    txn(0, 1'b1, 2'b10, 32'h0, 32'hAABBCCDD, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b1, 2'b00, 32'h3, 32'h55000000, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h0, 32'h0,        1'b0, 1, 3, 1'b1, 32'h55BBCCDD);
    txn(0, 1'b1, 2'b01, 32'h0, 32'hFFFF1234, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b00, 32'h2, 32'h0,        1'b0, 1, 3, 1'b1, 32'h55BB1234);
    txn(0, 1'b1, 2'b01, 32'h3, 32'h9999EEEE, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h0, 32'h0,        1'b0, 1, 3, 1'b1, 32'h99991234);
    txn(0, 1'b1, 2'b11, 32'h1, 32'h0F0E0D0C, 1'b0, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h0, 32'h0,        1'b0, 1, 3, 1'b1, 32'h0F0E0D0C);

    // write-back then refill with inputs scrambled after accept; 0x1000 aliases to 0x0
    txn(0, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 1'b1, 1, 3, 1'b0, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h1000, 32'h0,        1'b1, 1, 3, 1'b1, 32'hDEADBEEF);
    txn(0, 1'b0, 2'b10, 32'h0,    32'h0,        1'b0, 1, 3, 1'b1, 32'hDEADBEEF);

    // zero latency, back-to-back read / write / read with req held
    txn(1, 1'b1, 2'b10, 32'h40, 32'hCAFE0001, 1'b0, 0, 1, 1'b0, 32'h0);
    data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h40; data_wdata = 32'h0;
    req[1] = 1'b1; k = 0; ap = '0; dp = '0; r1 = '0; r3 = '0; r5 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ap[i] = aok[1]; dp[i] = dok[1];
      if (i == 1) r1 = rdata[1];
      if (i == 3) r3 = rdata[1];
      if (i == 5) r5 = rdata[1];
      @(posedge clk); #1;
      if (ap[i]) begin
        k++;
        if (k == 1)      begin data_wr = 1'b1; data_wdata = 32'h12345678; end
        else if (k == 2) begin data_wr = 1'b0; data_wdata = 32'h0; end
        else             req[1] = 1'b0;
      end
    end
    exp_rd[1] += 2; exp_wr[1] += 1;
    chk("z_aok_pattern", {26'd0, ap}, 32'h15);
    chk("z_dok_pattern", {26'd0, dp}, 32'h2A);
    chk("z_rd1", r1, 32'hCAFE0001);
    chk("z_rdata_hold", r3, 32'hCAFE0001);
    chk("z_rd2", r5, 32'h12345678);
    chk("z_rdc", rdc[1], 32'(exp_rd[1]));
    chk("z_wrc", wrc[1], 32'(exp_wr[1]));

    // request withdrawn before ADDR_LAT=3, then full latency again
    req[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_no_accept", {31'd0, aok[2]}, 32'd0);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    @(negedge clk);
    chk("w_dropped", {31'd0, aok[2]}, 32'd0);
    @(posedge clk); #1;
    txn(2, 1'b1, 2'b10, 32'h20, 32'h00000077, 1'b0, 3, 2, 1'b0, 32'h0);

    // reset during WAIT of a write
    txn(0, 1'b1, 2'b10, 32'h8, 32'h0, 1'b0, 1, 3, 1'b0, 32'h0);
    data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h8; data_wdata = 32'hFFFFFFFF;
    req[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_case_accept", {31'd0, aok[0]}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      seen |= dok[0];
      @(posedge clk); #1;
      rst = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin exp_rd[i] = 0; exp_wr[i] = 0; end
    chk("rst_no_dok", {31'd0, seen}, 32'd0);
    chk("rst_wrc_cleared", wrc[0], 32'h0);
    chk("rst_rdc_cleared", rdc[0], 32'h0);
    chk("rst_rdata_cleared", rdata[0], 32'h0);
    txn(0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b0, 1, 3, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_data_mem.md
# sram_like_data_mem

Single-port data memory responding on the SRAM-like (req / addr_ok / data_ok) bus that the data cache drives as initiator on refills and dirty-line write-backs. It accepts one transaction at a time, inserts programmable address-accept and data-return latencies, and applies byte-masked writes using the cache's size/offset encoding. It sits behind the cache in the simulation and FPGA memory subsystem, and it is also the reference slave used in cache testbenches.

## Interface
- `ADDR_LAT`, default 1: cycles `req` must be held in IDLE before `addr_ok` (0..15).
- `DATA_LAT`, default 2: extra cycles between the accept cycle and the `data_ok` cycle (0..15).
- `MEM_AW`, default 12: word-address width; depth is 2^MEM_AW words.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `data_req`  in  1  request valid from the initiator.
- `data_wr`  in  1  1 = write, 0 = read.
- `data_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `data_addr`  in  32  byte address.
- `data_wdata`  in  32  write data, lane-aligned as on the bus.
- `data_rdata`  out  32  read word; valid in the `data_ok` cycle of a read.
- `data_addr_ok`  out  1  address accepted (one-cycle pulse).
- `data_data_ok`  out  1  transaction complete (one-cycle pulse).
- `rd_count`  out  32  completed reads since reset.
- `wr_count`  out  32  completed writes since reset.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `acnt` (4 bits) increments each cycle `data_req` = 1 and `acnt` < `ADDR_LAT`. It clears when `data_req` = 0.
- `data_addr_ok` = `data_req` & (state == IDLE) & (`acnt` == `ADDR_LAT`). This is combinational; with `ADDR_LAT` = 0 it is accepted in the same cycle `req` rises.
- Accept cycle, on the `addr_ok` handshake:
  - latch `wr`, `addr[MEM_AW+1:2]` as the index, the byte mask, and `wdata`;
  - load `dcnt` = `DATA_LAT` and clear `acnt`;
  - next state is RESP if `DATA_LAT` = 0, else WAIT.
- WAIT: `dcnt` decrements each cycle; when `dcnt` == 1, next state is RESP.
- RESP: `data_data_ok` = 1 for exactly one cycle, then back to IDLE.
  - Read: `data_rdata` = mem[index], the full word regardless of size.
  - Write: `mem[index]` = old & ~M | wdata & M at the RESP clock edge, where M expands each mask bit to 8 bits.
  - The matching counter increments at the same edge.
- Byte mask:
  - byte size: one-hot at `addr[1:0]` (00 → 0001, 11 → 1000);
  - half size: `addr[1]` ? 1100 : 0011, with `addr[0]` ignored;
  - word or size 11: 1111, with `addr[1:0]` ignored.
- Address bits above `MEM_AW+1` are ignored, so addresses alias modulo the depth.
- Only one transaction is outstanding. `addr_ok` is 0 in WAIT and RESP even if `req` is high. A `req` held through RESP is counted from 0 again in IDLE the next cycle.
- Inputs other than `req` are sampled only in the accept cycle. Later changes to addr, wdata or size never affect the pending transaction.
- Memory contents are not reset. A read of a never-written word returns X in simulation; benches preload it.

## Timing
- Reset values: state IDLE; `acnt`, `dcnt` = 0; `addr_ok` = 0; `data_ok` = 0; `rdata` = 0; `rd_count`, `wr_count` = 0.
- `rdata` holds its last read value across writes and idle cycles.
- Accept-to-`data_ok` latency is `DATA_LAT` + 1 cycles. The minimum is `data_ok` in the cycle after `addr_ok`; never the same cycle.
- `req`-rise-to-`addr_ok` latency is `ADDR_LAT` cycles when `req` is held continuously.
- Back-to-back transactions: the earliest next accept is the cycle after RESP. Write-back followed by refill costs (`ADDR_LAT` + `DATA_LAT` + 2) × 2 cycles minimum.
- Reset asserted mid-transaction:
  - the pending transaction is dropped, and a pending write is not performed;
  - the next cycle is IDLE with counters cleared;
  - memory is untouched.
- Reset and RESP in the same cycle: reset wins. No write occurs and no count increments, but `data_ok` is still driven combinationally in that cycle.
- Counters wrap modulo 2^32.

## Test plan
- **Read with latencies:** `ADDR_LAT`=1, `DATA_LAT`=2, mem[5]=0x11223344; read at 0x14.
  - `addr_ok` is 1 cycle after `req`, `data_ok` is 3 cycles after `addr_ok`, `rdata`=0x11223344, `rd_count`=1.
- **Byte and half writes:** mem[0]=0xAABBCCDD.
  - sb 0x55 at 0x3 → mem[0]=0x55BBCCDD;
  - sh 0x1234 (lanes 0-1) at 0x0 → 0x55BB1234;
  - word read returns 0x55BB1234.
- **Zero latency:** `ADDR_LAT`=0, `DATA_LAT`=0.
  - `addr_ok` in the same cycle as `req`, `data_ok` in the next cycle, back-to-back read/write/read.
  - Accepts are exactly 2 cycles apart and `addr_ok` is never high in RESP.
- **Write-back then refill:**
  - write 0xDEADBEEF at 0x1000, then read 0x1000 while `wdata` and `addr` change after accept;
  - the read returns 0xDEADBEEF, and aliasing (`MEM_AW`=10) makes 0x0 return the same word.
- **Reset mid-write:** reset asserted in WAIT of a write of 0xFFFFFFFF to 0x8 (old 0x0).
  - After reset: `data_ok` is never pulsed, mem[2]=0x0, `wr_count`=0, and a new read is accepted normally.
- **Request withdrawn:** `req` dropped before `acnt` reaches `ADDR_LAT`=3.
  - No accept occurs; re-raising `req` takes the full 3 cycles again.
